pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the fixed-width, always-advancing inter-stage registers (ID/MEM style) of the accumulator CPU. Back-pressure from a slow memory or accumulator stage can stall the pipe without dropping instructions, and a branch/exception can squash in-flight work. Control fields leaving the stage are forced to zero on bubbles, so a stale write enable can never fire.

---
 rtl/pipe_stage_skid.sv | 80 ++++++++
 tb/tb_pipe_stage_skid.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a one-entry skid buffer, flush and saturating stall counter
module pipe_stage_skid #(
   parameter int OPCODE_W = 3,
   parameter int ADDR_W   = 5,
   parameter int CTRL_W   = 4,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] in_opcode,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [CTRL_W-1:0]   in_ctrl,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [CTRL_W-1:0]   out_ctrl,
   input  logic                flush,
   input  logic                clr_cnt,
   output logic [CNT_W-1:0]    stall_cnt
);
   localparam int DW = OPCODE_W + ADDR_W + CTRL_W;
   logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   logic [DW-1:0]    m_data_q, m_data_d, s_data_q, s_data_d, in_data;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, pop;
   assign in_data    = {in_ctrl, in_addr, in_opcode};
   assign in_ready   = ~s_valid_q;
   assign accept     = in_valid & in_ready;
   assign pop        = m_valid_q & out_ready;
   assign out_valid  = m_valid_q;
   assign out_opcode = m_data_q[OPCODE_W-1:0];
   assign out_addr   = m_data_q[OPCODE_W +: ADDR_W];
   // bubbles must never leak a stale write enable downstream
   assign out_ctrl   = m_valid_q ? m_data_q[DW-1 -: CTRL_W] : '0;
   assign stall_cnt  = cnt_q;
   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (s_valid_q) begin
         if (pop) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!m_valid_q || pop) begin
            m_data_d  = in_data;
            m_valid_d = 1'b1;
         end else begin
            s_data_d  = in_data;
            s_valid_d = 1'b1;
         end
      end else if (pop) begin
         m_valid_d = 1'b0;
      end
      cnt_d = clr_cnt ? '0 : (m_valid_q && !out_ready && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_data_q  <= '0;
         s_data_q  <= '0;
         cnt_q     <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_data_q  <= m_data_d;
         s_data_q  <= s_data_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized and directed scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, clr_cnt = 1'b0;
   logic in_ready, out_valid;
   logic [2:0] in_opcode = '0, out_opcode;
   logic [4:0] in_addr = '0, out_addr;
   logic [3:0] in_ctrl = '0, out_ctrl;
   logic [CNT_W-1:0] stall_cnt;
   logic [11:0] exp_q[$];
   int wr_ptr = 0, rd_ptr = 0, occ = 0, cnt_m = 0;
   int vectors = 0, errs = 0;
   logic prev_rst = 1'b1;

   pipe_stage_skid #(.OPCODE_W(3), .ADDR_W(5), .CTRL_W(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_addr(in_addr), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_addr(out_addr), .out_ctrl(out_ctrl), .flush(flush),
      .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         errs++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endfunction

   // reference: the stage is an in-order queue of capacity two; occ is its size entering this cycle
   always @(negedge clk, posedge rst, negedge rst) begin
      if (rst) begin
         rd_ptr   = wr_ptr;
         cnt_m    = 0;
         prev_rst = 1'b1;
      end else if (prev_rst) begin
         prev_rst = 1'b0;
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_ctrl", int'(out_ctrl), 0);
         chk("rst_out_opcode", int'(out_opcode), 0);
         chk("rst_out_addr", int'(out_addr), 0);
         chk("rst_in_ready", int'(in_ready), 1);
         chk("rst_stall_cnt", int'(stall_cnt), 0);
      end else begin
         chk("out_valid", int'(out_valid), int'(occ > 0));
         chk("in_ready", int'(in_ready), int'(occ < 2));
         chk("stall_cnt", int'(stall_cnt), cnt_m);
         if (!out_valid) chk("bubble_ctrl", int'(out_ctrl), 0);
         else if (occ > 0) chk("head", int'({out_ctrl, out_addr, out_opcode}), int'(exp_q[rd_ptr]));
         cnt_m = clr_cnt ? 0 : (occ > 0 && !out_ready && cnt_m < CNT_MAX) ? cnt_m + 1 : cnt_m;
         if (flush) rd_ptr = wr_ptr;
         else if (occ > 0 && out_ready) rd_ptr++;
      end
   end

   task automatic cyc(input logic v, input logic [2:0] op, input logic [4:0] ad, input logic [3:0] ct,
                      input logic ordy, input logic fl, input logic clr);
      @(posedge clk);
      #1;
      in_valid = v; in_opcode = op; in_addr = ad; in_ctrl = ct;
      out_ready = ordy; flush = fl; clr_cnt = clr;
      occ = wr_ptr - rd_ptr;
      if (v && occ < 2 && !fl) begin
         exp_q.push_back({ct, ad, op});
         wr_ptr++;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 8; i++) cyc(1, 3'(i), 5'(i * 3), 4'(i), 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 3'd1, 5'd5, 4'd1, 0, 0, 0);
      cyc(1, 3'd2, 5'd9, 4'd8, 0, 0, 0);
      repeat (3) cyc(1, 3'd3, 5'd17, 4'd4, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 3'd4, 5'd2, 4'b0010, 1, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 3'd5, 5'd6, 4'd3, 0, 0, 0);
      cyc(1, 3'd6, 5'd7, 4'd5, 0, 0, 0);
      cyc(1, 3'd7, 5'd31, 4'd15, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 3'd2, 5'd12, 4'd9, 0, 0, 0);
      repeat (20) cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 3'd3, 5'd10, 4'd7, 0, 0, 0);
      cyc(1, 3'd4, 5'd11, 4'd6, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      occ = 0;
      repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 400; i++) begin
         logic [11:0] r;
         logic [7:0] k;
         r = 12'($urandom());
         k = 8'($urandom());
         cyc(k[1:0] != 2'b00, r[2:0], r[7:3], r[11:8], k[3:2] != 2'b00,
             k[7:4] == 4'd0, k[7:4] == 4'd15 && k[0]);
      end
      repeat (4) cyc(0, 0, 0, 0, 1, 0, 0);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
